// File: rtl/idct_pkg.sv
// Shared constants for the 8x8 inverse DCT: Q16.16 cosine table indexed [k][n],
// FSM state encoding, and the JPEG pixel-domain level-shift and clamp points.
package idct_pkg;

   localparam int FRAC_BITS_DEF = 16;
   localparam int COEF_W        = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROW  = 2'd1,
      COL  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int LVL_SHIFT_INT = 128;
   localparam int CLAMP_MAX_INT = 255;

   // round(c(k)/2 * cos(j*pi/16) * 2^16); the table assumes 16 fractional bits
   localparam logic signed [COEF_W-1:0] K0 = 32'sd23170;
   localparam logic signed [COEF_W-1:0] A1 = 32'sd32138;
   localparam logic signed [COEF_W-1:0] A2 = 32'sd30274;
   localparam logic signed [COEF_W-1:0] A3 = 32'sd27246;
   localparam logic signed [COEF_W-1:0] A4 = 32'sd23170;
   localparam logic signed [COEF_W-1:0] A5 = 32'sd18205;
   localparam logic signed [COEF_W-1:0] A6 = 32'sd12540;
   localparam logic signed [COEF_W-1:0] A7 = 32'sd6393;

   localparam logic signed [COEF_W-1:0] COEF [8][8] = '{
      '{ K0,  K0,  K0,  K0,  K0,  K0,  K0,  K0},
      '{ A1,  A3,  A5,  A7, -A7, -A5, -A3, -A1},
      '{ A2,  A6, -A6, -A2, -A2, -A6,  A6,  A2},
      '{ A3, -A7, -A1, -A5,  A5,  A1,  A7, -A3},
      '{ A4, -A4, -A4,  A4,  A4, -A4, -A4,  A4},
      '{ A5, -A1,  A7,  A3, -A3, -A7,  A1, -A5},
      '{ A6, -A2,  A2, -A6, -A6,  A2, -A2,  A6},
      '{ A7, -A5,  A3, -A1,  A1, -A3,  A5, -A7}
   };

endpackage

// File: rtl/idct_dot8.sv
// Combinational 8-term signed dot product: full-width products and sum,
// round-half-up at FRAC_BITS, then saturate to the signed DATA_WIDTH range.
module idct_dot8
   import idct_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
   input  logic signed [DATA_WIDTH-1:0] i_a [8],
   input  logic signed [DATA_WIDTH-1:0] i_c [8],
   output logic signed [DATA_WIDTH-1:0] o_y
);

   localparam int W  = DATA_WIDTH;
   localparam int SW = 2 * W + 3;

   localparam logic signed [SW-1:0] RND  = SW'(1) <<< (FRAC_BITS - 1);
   localparam logic signed [SW-1:0] MAXV = SW'({1'b0, {(W-1){1'b1}}});
   localparam logic signed [SW-1:0] MINV = ~MAXV;

   logic signed [2*W-1:0] w_prod [8];
   logic signed [SW-1:0]  w_acc  [9];
   logic signed [SW-1:0]  w_rnd;
   logic signed [SW-1:0]  w_shr;

   assign w_acc[0] = '0;

   for (genvar g = 0; g < 8; g++) begin : g_mac
      assign w_prod[g]  = (2*W)'(i_a[g]) * (2*W)'(i_c[g]);
      assign w_acc[g+1] = w_acc[g] + SW'(w_prod[g]);
   end

   assign w_rnd = w_acc[8] + RND;
   assign w_shr = w_rnd >>> FRAC_BITS;

   assign o_y = (w_shr > MAXV) ? MAXV[W-1:0] :
                (w_shr < MINV) ? MINV[W-1:0] :
                w_shr[W-1:0];

endmodule

// File: rtl/idct_2d_8x8.sv
// 8x8 2D inverse DCT, row then column pass on one shared dot8, 128 cycles accept-to-valid,
// one block in flight; optional IDCT_LEVEL_SHIFT_EN adds 128.0 and clamps to [0,255].
module idct_2d_8x8
   import idct_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH*64-1:0] in_matrix,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH*64-1:0] out_matrix
);

   localparam int W = DATA_WIDTH;

   state_t               r_state;
   logic [5:0]           r_idx;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic [W*64-1:0]      r_out_matrix;
   logic signed [W-1:0]  r_in_buf  [64];
   logic signed [W-1:0]  r_t_buf   [64];
   logic signed [W-1:0]  r_out_buf [64];

   logic [2:0]           w_hi;
   logic [2:0]           w_lo;
   logic signed [W-1:0]  w_a [8];
   logic signed [W-1:0]  w_c [8];
   logic signed [W-1:0]  w_dot;
   logic signed [W-1:0]  w_col_val;
   logic [W*64-1:0]      w_out_next;

   assign w_hi = r_idx[5:3];
   assign w_lo = r_idx[2:0];

   // ROW: idx = r*8+n, taps walk in_buf[r][k]; COL: idx = m*8+n, taps walk T[k][n]
   for (genvar g = 0; g < 8; g++) begin : g_tap
      assign w_a[g] = (r_state == COL) ? r_t_buf[{3'(g), w_lo}] : r_in_buf[{w_hi, 3'(g)}];
      assign w_c[g] = (r_state == COL) ? W'(COEF[g][w_hi]) : W'(COEF[g][w_lo]);
   end

   idct_dot8 #(
      .DATA_WIDTH (W),
      .FRAC_BITS  (FRAC_BITS)
   ) u_dot8 (
      .i_a (w_a),
      .i_c (w_c),
      .o_y (w_dot)
   );

`ifdef IDCT_LEVEL_SHIFT_EN
   localparam logic signed [W:0] LS   = (W+1)'(LVL_SHIFT_INT) <<< FRAC_BITS;
   localparam logic signed [W:0] CMAX = (W+1)'(CLAMP_MAX_INT) <<< FRAC_BITS;

   logic signed [W:0] w_shift;

   assign w_shift   = {w_dot[W-1], w_dot} + LS;
   assign w_col_val = w_shift[W]      ? '0 :
                      (w_shift > CMAX) ? CMAX[W-1:0] :
                      w_shift[W-1:0];
`else
   assign w_col_val = w_dot;
`endif

   // Output image as it stands once the final COL element lands this cycle
   always_comb begin
      w_out_next = '0;
      for (int i = 0; i < 63; i++) begin
         w_out_next[i*W +: W] = r_out_buf[i[5:0]];
      end
      w_out_next[63*W +: W] = w_col_val;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_matrix <= '0;
         for (int i = 0; i < 64; i++) begin
            r_in_buf[i[5:0]]  <= '0;
            r_t_buf[i[5:0]]   <= '0;
            r_out_buf[i[5:0]] <= '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  for (int i = 0; i < 64; i++) begin
                     r_in_buf[i[5:0]] <= in_matrix[i*W +: W];
                  end
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= ROW;
               end
            end
            ROW: begin
               r_t_buf[r_idx] <= w_dot;
               r_idx          <= r_idx + 6'd1;
               if (r_idx == 6'd63) begin
                  r_state <= COL;
               end
            end
            COL: begin
               r_out_buf[r_idx] <= w_col_val;
               r_idx            <= r_idx + 6'd1;
               if (r_idx == 6'd63) begin
                  r_state      <= DONE;
                  r_out_valid  <= 1'b1;
                  r_out_matrix <= w_out_next;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_matrix = r_out_matrix;

endmodule

// File: tb/tb_idct_2d_8x8.sv
// Scoreboard bench for idct_2d_8x8: directed blocks with hand-computed Q16.16 results,
// expected blocks queued at issue and checked by a monitor at each output handshake.
module tb_idct_2d_8x8;

   localparam int W  = 32;
   localparam int NB = W * 64;

`ifdef IDCT_LEVEL_SHIFT_EN
   localparam logic signed [31:0] OFS = 32'sh0080_0000;
`else
   localparam logic signed [31:0] OFS = 32'sh0000_0000;
`endif

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [NB-1:0] in_matrix = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [NB-1:0] out_matrix;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [NB-1:0] exp_q  [$];
   int            tol_q  [$];
   string         name_q [$];
   int            acc_q  [$];
   logic          prev_valid = 1'b0;

   // C[0][r]*C[1][c] in Q16.16 for c = 0..7 (same magnitudes used for the transposed case)
   int ac_tab [8] = '{11363, 9633, 6436, 2260, -2260, -6436, -9633, -11363};

   idct_2d_8x8 #(
      .DATA_WIDTH (W),
      .FRAC_BITS  (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_matrix  (in_matrix),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_matrix (out_matrix)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string nm, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   task automatic check_tol(input string nm, input int idx, input logic signed [31:0] got,
                            input logic signed [31:0] want, input int tol);
      longint d;
      d = longint'(got) - longint'(want);
      if (d < 0) d = -d;
      n_cmp++;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s[%0d]: got 0x%08h, want 0x%08h +/-%0d", nm, idx, got, want, tol);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: bound expired or event missing", nm);
   endtask

   function automatic logic [NB-1:0] fill(input logic signed [31:0] v);
      logic [NB-1:0] r;
      for (int i = 0; i < 64; i++) r[i*W +: W] = v;
      return r;
   endfunction

   function automatic logic [NB-1:0] one_elem(input int idx, input logic [31:0] v);
      logic [NB-1:0] r;
      r = '0;
      r[idx*W +: W] = v;
      return r;
   endfunction

   // by_col=1: value depends on column c; otherwise on row r
   function automatic logic [NB-1:0] ac_block(input bit by_col);
      logic [NB-1:0] r;
      for (int i = 0; i < 64; i++) begin
         r[i*W +: W] = 32'(ac_tab[by_col ? (i % 8) : (i / 8)]) + OFS;
      end
      return r;
   endfunction

   // Monitor: latency on out_valid rise, element-wise compare at each output handshake
   always @(negedge clk) begin : monitor
      logic [NB-1:0] ev;
      int            tl;
      int            a;
      string         nm;
      if (reset) begin
         exp_q.delete();
         tol_q.delete();
         name_q.delete();
         acc_q.delete();
         prev_valid <= 1'b0;
      end else begin
         if (in_valid && in_ready) acc_q.push_back(cyc);
         if (out_valid && !prev_valid) begin
            if (acc_q.size() == 0) begin
               fail_now("latency_no_accept");
            end else begin
               a = acc_q.pop_front();
               check_eq("latency", cyc - a - 1, 128);
            end
         end
         prev_valid <= out_valid;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_output");
            end else begin
               ev = exp_q.pop_front();
               tl = tol_q.pop_front();
               nm = name_q.pop_front();
               for (int i = 0; i < 64; i++) begin
                  check_tol(nm, i, out_matrix[i*W +: W], ev[i*W +: W], tl);
               end
            end
         end
      end
   end

   task automatic issue(input logic [NB-1:0] blk, input logic [NB-1:0] expv,
                        input int tol, input string nm);
      int t;
      exp_q.push_back(expv);
      tol_q.push_back(tol);
      name_q.push_back(nm);
      in_matrix = blk;
      in_valid  = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) fail_now({"accept_", nm});
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_matrix = '0;
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) fail_now({"drain_", nm});
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [NB-1:0] snap;
      int            unstable;
      int            irdy;
      int            n;
      int            nz;
      int            t;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      nz = 0;
      for (int i = 0; i < 64; i++) if (out_matrix[i*W +: W] != 32'h0) nz++;
      check_eq("rst_out_matrix_nonzero", nz, 0);

      @(posedge clk);
      #1 out_ready = 1'b1;
      issue('0, fill(OFS), 4, "zero_block");
      drain("zero_block");

      issue(one_elem(0, 32'h0008_0000), fill(32'h0000_FFFE + OFS), 4, "dc_8p0");
      drain("dc_8p0");

      issue(one_elem(1, 32'h0001_0000), ac_block(1'b1), 4, "ac_x01");
      drain("ac_x01");

      // Backpressure: first block held 50 cycles while a second waits at the input
      out_ready = 1'b0;
      issue(one_elem(0, 32'hFFF8_0000), fill(32'hFFFF_0002 + OFS), 4, "bp_first");
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) fail_now("bp_valid");
      snap = out_matrix;
      @(posedge clk);
      #1;
      exp_q.push_back(ac_block(1'b0));
      tol_q.push_back(4);
      name_q.push_back("bp_second_x10");
      in_matrix = one_elem(8, 32'h0001_0000);
      in_valid  = 1'b1;
      unstable = 0;
      irdy = 0;
      repeat (50) begin
         @(negedge clk);
         if (out_matrix !== snap || !out_valid) unstable++;
         if (in_ready) irdy++;
      end
      check_eq("bp_out_stable_violations", unstable, 0);
      check_eq("bp_in_ready_high_cycles", irdy, 0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 10);
      check_eq("bp_accept_delay", n, 2);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_matrix = '0;
      drain("bp_second");

      // Reset during COL idx 20: block discarded, then a clean block
      issue(one_elem(0, 32'h0008_0000), fill(32'h0000_FFFE + OFS), 4, "aborted");
      repeat (84) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("midcol_rst_in_ready", in_ready, 1);
      check_eq("midcol_rst_out_valid", out_valid, 0);
      check_eq("midcol_rst_queue_cleared", exp_q.size(), 0);
      @(posedge clk);
      #1;
      issue(one_elem(0, 32'hFFF8_0000), fill(32'hFFFF_0002 + OFS), 4, "after_rst_dc");
      drain("after_rst_dc");

`ifdef IDCT_LEVEL_SHIFT_EN
      issue(one_elem(0, 32'hFC00_0000), fill(32'h0000_0000), 1024, "ls_m1024");
      drain("ls_m1024");
      issue(one_elem(0, 32'h0410_0000), fill(32'h00FF_0000), 4, "ls_p1040");
      drain("ls_p1040");
`endif

      repeat (5) @(posedge clk);
      check_eq("final_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
